alu_seq: RTL and testbench

- Multi-cycle ALU that produces the result and condition flags for the flag register stage directly downstream.
- Single-cycle arithmetic/logic ops run in 1 cycle. MUL uses iterative shift-add, and shifts move one bit per cycle.
- Start/busy/done handshake with the sequencer. Flag outputs are wired straight to the flag register's C/OV/P/Z/S inputs and its C_OV_en.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_seq.sv | 38 +++
 rtl/alu_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and helpers for the sequential ALU
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_ADC = 4'd1,
        ALU_SUB = 4'd2,
        ALU_SBB = 4'd3,
        ALU_CMP = 4'd4,
        ALU_AND = 4'd5,
        ALU_OR  = 4'd6,
        ALU_XOR = 4'd7,
        ALU_NOT = 4'd8,
        ALU_INC = 4'd9,
        ALU_DEC = 4'd10,
        ALU_MUL = 4'd11,
        ALU_SHL = 4'd12,
        ALU_SHR = 4'd13
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_MUL   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } alu_state_t;

    // Even parity of a zero-extended value; extra zero bits do not change the count
    function automatic logic parity_even(input logic [63:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier, one partial product per step
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     acc;

    // Multiplier sits in the low half and is consumed LSB first while the accumulator shifts right
    always_comb begin
        acc     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{prod_q[0]}}};
        mcand_d = load ? a : mcand_q;
        prod_d  = load ? {{WIDTH{1'b0}}, b} : step ? {acc, prod_q[WIDTH-1:1]} : prod_q;
    end

    // Operand and partial-product registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    assign product = prod_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake feeding the flag register
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  alu_op_t          opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             C_prev,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             result_we,
    output logic             C_flag,
    output logic             OV_flag,
    output logic             P_flag,
    output logic             Z_flag,
    output logic             S_flag,
    output logic             C_OV_en
);

    localparam int CW = $clog2(WIDTH + 1);

    alu_state_t         state_q, state_d;
    alu_op_t            op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               c_q, c_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d, res_hi_q, res_hi_d;
    logic               cf_q, cf_d, of_q, of_d, pf_q, pf_d, zf_q, zf_d, sf_q, sf_d;
    logic [CW-1:0]      shamt;
    logic               is_sub, cin, mul_load, mul_step, finish;
    logic [WIDTH-1:0]   bx, ex_res, fin_res, fin_hi;
    logic [WIDTH:0]     sum;
    logic               ex_c, ex_ov, fin_c, fin_ov;
    logic [2*WIDTH-1:0] product;

    assign shamt = CW'(32'(b) % WIDTH);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .step    (mul_step),
        .a       (a),
        .b       (b),
        .product (product)
    );

    // Shared adder: subtraction adds ~b with carry-in 1 (or ~C_prev for SBB); borrow is the inverted carry
    always_comb begin
        is_sub = op_q inside {ALU_SUB, ALU_SBB, ALU_CMP};
        bx     = is_sub ? ~b_q : b_q;
        cin    = op_q == ALU_ADC ? c_q : op_q == ALU_SBB ? ~c_q : is_sub;
        sum    = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    end

    // Single-cycle result; shifts reach here only with a zero amount and pass a through
    always_comb begin
        ex_res = '0;
        ex_c   = 1'b0;
        ex_ov  = 1'b0;
        case (op_q)
            ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBB, ALU_CMP: begin
                ex_res = sum[WIDTH-1:0];
                ex_c   = is_sub ? ~sum[WIDTH] : sum[WIDTH];
                ex_ov  = (a_q[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_AND:          ex_res = a_q & b_q;
            ALU_OR:           ex_res = a_q | b_q;
            ALU_XOR:          ex_res = a_q ^ b_q;
            ALU_NOT:          ex_res = ~a_q;
            ALU_INC:          ex_res = a_q + WIDTH'(1);
            ALU_DEC:          ex_res = a_q - WIDTH'(1);
            ALU_SHL, ALU_SHR: ex_res = a_q;
            default:          ex_res = '0;
        endcase
    end

    // Select the finishing value by the path that produced it
    always_comb begin
        fin_res = state_q == S_MUL ? product[WIDTH-1:0] : state_q == S_SHIFT ? a_q : ex_res;
        fin_hi  = state_q == S_MUL ? product[2*WIDTH-1:WIDTH] : '0;
        fin_c   = state_q == S_MUL ? |fin_hi : state_q == S_SHIFT ? c_q : ex_c;
        fin_ov  = state_q == S_MUL ? |fin_hi : state_q == S_SHIFT ? 1'b0 : ex_ov;
    end

    // Control FSM: accept in IDLE, iterate in MUL/SHIFT, latch result and flags on entry to DONE
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        cf_d     = cf_q;
        of_d     = of_q;
        pf_d     = pf_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        finish   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = opcode;
                    a_d      = a;
                    b_d      = b;
                    c_d      = C_prev;
                    mul_load = opcode == ALU_MUL;
                    if (opcode == ALU_MUL) begin
                        state_d = S_MUL;
                        cnt_d   = CW'(WIDTH);
                    end else if ((opcode == ALU_SHL || opcode == ALU_SHR) && shamt != '0) begin
                        state_d = S_SHIFT;
                        cnt_d   = shamt;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: finish = 1'b1;
            S_MUL: begin
                if (cnt_q == '0) begin
                    finish = 1'b1;
                end else begin
                    mul_step = 1'b1;
                    cnt_d    = cnt_q - CW'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    finish = 1'b1;
                end else begin
                    a_d   = op_q == ALU_SHL ? a_q << 1 : a_q >> 1;
                    c_d   = op_q == ALU_SHL ? a_q[WIDTH-1] : a_q[0];
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (finish) begin
            state_d  = S_DONE;
            res_d    = fin_res;
            res_hi_d = fin_hi;
            cf_d     = fin_c;
            of_d     = fin_ov;
            pf_d     = parity_even(64'(fin_res));
            zf_d     = {fin_hi, fin_res} == '0;
            sf_d     = state_q == S_MUL ? fin_hi[WIDTH-1] : fin_res[WIDTH-1];
        end
    end

    // State, operand and held-result registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            cf_q     <= 1'b0;
            of_q     <= 1'b0;
            pf_q     <= 1'b0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            cf_q     <= cf_d;
            of_q     <= of_d;
            pf_q     <= pf_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign result    = res_q;
    assign result_hi = res_hi_q;
    assign C_flag    = cf_q;
    assign OV_flag   = of_q;
    assign P_flag    = pf_q;
    assign Z_flag    = zf_q;
    assign S_flag    = sf_q;
    assign result_we = done && op_q != ALU_CMP;
    assign C_OV_en   = done && (op_q inside {ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBB, ALU_CMP,
                                             ALU_MUL, ALU_SHL, ALU_SHR});

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq at WIDTH=8
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        string      tag;
        int         acc;
        int         lat;
        logic [7:0] res;
        logic [7:0] hi;
        logic       c, ov, p, z, s, we, en;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    alu_op_t    opcode = ALU_ADD;
    logic [7:0] a = '0, b = '0;
    logic       C_prev = 1'b0;
    logic       busy, done, result_we, C_flag, OV_flag, P_flag, Z_flag, S_flag, C_OV_en;
    logic [7:0] result, result_hi;

    int   checks = 0, failures = 0, cyc = 0, issued = 0, done_cnt = 0;
    exp_t sb[$];
    exp_t cur;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a), .b(b), .C_prev(C_prev),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi), .result_we(result_we),
        .C_flag(C_flag), .OV_flag(OV_flag), .P_flag(P_flag), .Z_flag(Z_flag), .S_flag(S_flag),
        .C_OV_en(C_OV_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input string tag, input alu_op_t op, input logic [7:0] ia,
                                   input logic [7:0] ib, input logic cp);
        exp_t e;
        int ai = int'(ia), bi = int'(ib), ci = int'(cp), r = 0, sr = 0;
        int sa = $signed(ia), sb_i = $signed(ib);
        int sh = bi % 8;
        logic [7:0] v = ia;
        logic [15:0] full = '0;
        e.tag = tag; e.acc = 0; e.lat = 1; e.hi = '0; e.c = 0; e.ov = 0; e.en = 0;
        e.we = op != ALU_CMP;
        case (op)
            ALU_ADD: begin r = ai + bi; sr = sa + sb_i; e.c = r > 255; e.en = 1; end
            ALU_ADC: begin r = ai + bi + ci; sr = sa + sb_i + ci; e.c = r > 255; e.en = 1; end
            ALU_SUB, ALU_CMP: begin r = ai - bi; sr = sa - sb_i; e.c = ai < bi; e.en = 1; end
            ALU_SBB: begin r = ai - bi - ci; sr = sa - sb_i - ci; e.c = ai < bi + ci; e.en = 1; end
            ALU_AND: r = ai & bi;
            ALU_OR:  r = ai | bi;
            ALU_XOR: r = ai ^ bi;
            ALU_NOT: r = 255 - ai;
            ALU_INC: r = ai + 1;
            ALU_DEC: r = ai - 1;
            ALU_MUL: begin r = ai * bi; e.lat = 9; e.en = 1; end
            ALU_SHL, ALU_SHR: begin
                for (int i = 0; i < sh; i++) begin
                    e.c = op == ALU_SHL ? v[7] : v[0];
                    v = op == ALU_SHL ? {v[6:0], 1'b0} : {1'b0, v[7:1]};
                end
                r = int'(v); e.lat = sh + 1; e.en = 1;
            end
            default: r = 0;
        endcase
        e.ov = (sr > 127) || (sr < -128);
        full = r[15:0];
        e.res = full[7:0];
        if (op == ALU_MUL) begin
            e.hi = full[15:8];
            e.c = e.hi != 0;
            e.ov = e.c;
        end
        e.z = op == ALU_MUL ? full == 0 : e.res == 0;
        e.s = op == ALU_MUL ? full[15] : e.res[7];
        e.p = ($countones(e.res) % 2) == 0;
        return e;
    endfunction

    task automatic issue(input string tag, input alu_op_t op, input logic [7:0] ia,
                         input logic [7:0] ib, input logic cp);
        exp_t e;
        @(negedge clk);
        start = 1'b1; opcode = op; a = ia; b = ib; C_prev = cp;
        e = model(tag, op, ia, ib, cp);
        @(negedge clk);
        start = 1'b0;
        e.acc = cyc;
        sb.push_back(e);
        issued++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'd0, busy}, 0);
    endtask

    // Scoreboard: every done pops one expectation; outside done the strobes must stay low
    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                done_cnt++;
                chk("done_expected", {31'd0, sb.size() != 0}, 1);
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    chk({cur.tag, "_latency"}, cyc - cur.acc, cur.lat);
                    chk({cur.tag, "_busy"}, {31'd0, busy}, 1);
                    chk({cur.tag, "_result"}, {24'd0, result}, {24'd0, cur.res});
                    chk({cur.tag, "_result_hi"}, {24'd0, result_hi}, {24'd0, cur.hi});
                    chk({cur.tag, "_C"}, {31'd0, C_flag}, {31'd0, cur.c});
                    chk({cur.tag, "_OV"}, {31'd0, OV_flag}, {31'd0, cur.ov});
                    chk({cur.tag, "_P"}, {31'd0, P_flag}, {31'd0, cur.p});
                    chk({cur.tag, "_Z"}, {31'd0, Z_flag}, {31'd0, cur.z});
                    chk({cur.tag, "_S"}, {31'd0, S_flag}, {31'd0, cur.s});
                    chk({cur.tag, "_we"}, {31'd0, result_we}, {31'd0, cur.we});
                    chk({cur.tag, "_cov_en"}, {31'd0, C_OV_en}, {31'd0, cur.en});
                end
            end else begin
                chk("strobes_low", {30'd0, C_OV_en, result_we}, 0);
            end
        end
    end

    initial begin
        #3;
        chk("reset_outputs", {7'd0, busy, done, result, result_hi, C_flag, OV_flag, P_flag,
                              Z_flag, S_flag, result_we, C_OV_en}, 0);
        @(negedge clk);
        rst = 1'b1;

        issue("add_7f_01", ALU_ADD, 8'h7F, 8'h01, 1'b0); wait_idle();
        issue("adc_ff_00", ALU_ADC, 8'hFF, 8'h00, 1'b1); wait_idle();
        issue("cmp_05_05", ALU_CMP, 8'h05, 8'h05, 1'b0); wait_idle();

        issue("mul_10_20", ALU_MUL, 8'h10, 8'h20, 1'b0);
        for (int i = 1; i < 9; i++) begin
            chk("mul_busy", {31'd0, busy}, 1);
            if (i == 3) begin
                start = 1'b1; opcode = ALU_ADD; a = 8'h11; b = 8'h22;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        issue("shl_e1_3", ALU_SHL, 8'hE1, 8'd3, 1'b0); wait_idle();
        issue("shr_81_0", ALU_SHR, 8'h81, 8'd0, 1'b0); wait_idle();

        issue("and_f0_0f", ALU_AND, 8'hF0, 8'h0F, 1'b0);
        start = 1'b1; opcode = ALU_ADD; a = 8'h01; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        issue("sub_00_01", ALU_SUB, 8'h00, 8'h01, 1'b0); wait_idle();
        issue("sbb_80_00", ALU_SBB, 8'h80, 8'h00, 1'b1); wait_idle();
        issue("mul_ff_ff", ALU_MUL, 8'hFF, 8'hFF, 1'b0); wait_idle();
        issue("mul_00_5a", ALU_MUL, 8'h00, 8'h5A, 1'b0); wait_idle();
        issue("shr_81_9", ALU_SHR, 8'h81, 8'd9, 1'b0); wait_idle();
        issue("shl_01_7", ALU_SHL, 8'h01, 8'd7, 1'b0); wait_idle();
        issue("inc_ff", ALU_INC, 8'hFF, 8'h00, 1'b0); wait_idle();
        issue("dec_00", ALU_DEC, 8'h00, 8'h00, 1'b0); wait_idle();
        issue("not_a5", ALU_NOT, 8'hA5, 8'h00, 1'b0); wait_idle();
        issue("or_a0_05", ALU_OR, 8'hA0, 8'h05, 1'b0); wait_idle();
        issue("xor_ff_0f", ALU_XOR, 8'hFF, 8'h0F, 1'b0); wait_idle();
        issue("add_80_80", ALU_ADD, 8'h80, 8'h80, 1'b0); wait_idle();

        issue("mul_abort", ALU_MUL, 8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_outputs", {7'd0, busy, done, result, result_hi, C_flag, OV_flag, P_flag,
                              Z_flag, S_flag, result_we, C_OV_en}, 0);
        sb.delete();
        issued--;
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_not_resumed", {31'd0, busy}, 0);
        issue("add_01_01", ALU_ADD, 8'h01, 8'h01, 1'b0); wait_idle();

        repeat (12) @(negedge clk);
        chk("done_count", done_cnt, issued);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
